// File: rtl/calc_pkg.sv
// Shared opcode map, FSM states and helpers for the calculator command driver.
package calc_pkg;

  localparam int unsigned OP_ADD        = 0;
  localparam int unsigned OP_ADD_ALT    = 1;
  localparam int unsigned OP_SUB        = 2;
  localparam int unsigned OP_MUL        = 3;
  localparam int unsigned OP_DIV        = 4;
  localparam int unsigned OP_MOD        = 5;
  localparam int unsigned OP_AND        = 6;
  localparam int unsigned OP_OR         = 7;
  localparam int unsigned OP_NOT        = 8;
  localparam int unsigned OP_LT         = 9;
  localparam int unsigned OP_EQ         = 10;
  localparam int unsigned OP_GT         = 11;
  localparam int unsigned OP_LAST_LEGAL = 11;

  localparam logic [7:0] DIVZERO_RESULT = 8'hFF;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  function automatic logic is_div_zero(input int unsigned opc, input logic b_zero);
    return ((opc == OP_DIV) || (opc == OP_MOD)) && b_zero;
  endfunction

  function automatic logic is_err_cmd(input int unsigned opc, input logic b_zero);
    return (opc > OP_LAST_LEGAL) || is_div_zero(opc, b_zero);
  endfunction

endpackage

// File: rtl/calc_cmd_driver_sat_counter.sv
// Saturating event counter; holds at all-ones, cleared by synchronous reset.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/calc_cmd_driver.sv
// Sequential initiator for the combinational calculator: registers operands,
// waits a settle time, captures {overflow,result} and returns it with the tag.
module calc_cmd_driver
  import calc_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int OPC_W         = 4,
  parameter int TAG_W         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPC_W-1:0]  cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] calc_input1,
  output logic [DATA_W-1:0] calc_input2,
  output logic [OPC_W-1:0]  calc_opcode,
  input  logic [DATA_W-1:0] calc_result,
  input  logic              calc_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [CNT_W-1:0]  ovf_count,
  output logic [CNT_W-1:0]  err_count
);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       cmd_err, cmd_divz, rsp_fire;

  assign cmd_err  = is_err_cmd(32'(cmd_opcode), cmd_b == '0);
  assign cmd_divz = is_div_zero(32'(cmd_opcode), cmd_b == '0);
  assign rsp_fire = (state == RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Rejected commands also pass through DRIVE (with a zero count) so their
  // turnaround equals that of the fastest legal command.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = DRIVE;
      DRIVE:   if (settle_cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      calc_input1  <= '0;
      calc_input2  <= '0;
      calc_opcode  <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_tag      <= '0;
      settle_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          rsp_tag <= cmd_tag;
          if (cmd_err) begin
            rsp_result   <= cmd_divz ? DATA_W'(DIVZERO_RESULT) : '0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b1;
            settle_cnt   <= '0;
          end else begin
            calc_input1 <= cmd_a;
            calc_input2 <= cmd_b;
            calc_opcode <= cmd_opcode;
            rsp_err     <= 1'b0;
            settle_cnt  <= 4'(SETTLE_CYCLES - 1);
          end
        end
        DRIVE: begin
          if (settle_cnt != '0)
            settle_cnt <= settle_cnt - 1'b1;
          else if (!rsp_err) begin
            rsp_result   <= calc_result;
            rsp_overflow <= calc_overflow;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rsp_fire && rsp_overflow),
    .count (ovf_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rsp_fire && rsp_err),
    .count (err_count)
  );

endmodule

// File: doc/calc_cmd_driver.md
Name: calc_cmd_driver

Overview:
- Sequential initiator for the combinational 8-bit calculator. Accepts a tagged command (opcode, two operands) on a valid/ready interface.
- Drives the calculator's input1/input2/opcode from registers and waits a fixed settle time. It then captures {overflow, result} and returns it on a valid/ready response interface.
- Screens out divide/modulo-by-zero and unused opcodes, and keeps saturating overflow/error counters for debug.

Parameters:
- DATA_W, 8, operand/result width (calculator width)
- OPC_W, 4, opcode width
- TAG_W, 4, command tag width, echoed on the response
- SETTLE_CYCLES, 1, cycles the calculator inputs are held before capture (legal values 1..15)
- CNT_W, 8, width of the saturating statistics counters

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  driver can accept a command
- cmd_opcode  input  OPC_W  operation code
- cmd_a  input  DATA_W  operand 1
- cmd_b  input  DATA_W  operand 2
- cmd_tag  input  TAG_W  command tag
- calc_input1  output  DATA_W  to calculator input1
- calc_input2  output  DATA_W  to calculator input2
- calc_opcode  output  OPC_W  to calculator opcode
- calc_result  input  DATA_W  from calculator result
- calc_overflow  input  1  from calculator overflow (bit 8 of the 9-bit result)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_result  output  DATA_W  captured result
- rsp_overflow  output  1  captured overflow
- rsp_err  output  1  command rejected (div/mod by zero or unused opcode)
- rsp_tag  output  TAG_W  tag of the command
- busy  output  1  state != IDLE
- ovf_count  output  CNT_W  responses with overflow=1, saturating
- err_count  output  CNT_W  responses with err=1, saturating

Behaviour:
- Opcode map (fixed):
  - 0,1 add; 2 sub; 3 mul; 4 div; 5 mod
  - 6 logical AND; 7 logical OR; 8 NOT input1
  - 9 a<b; 10 a==b; 11 a>b; 12-15 unused
- Reset (sync, rst=1 at an edge): state=IDLE; all outputs 0, including calc_*, rsp_*, and both counters. Reset overrides any state, including DRIVE and RESP. A pending response is discarded with no handshake.
- States:
  - IDLE: cmd_ready=1, rsp_valid=0.
  - DRIVE: cmd_ready=0; a settle counter runs.
  - RESP: rsp_valid=1; rsp_* are held stable until rsp_ready=1.
- IDLE, cmd_valid=1, legal command: latch cmd_a/cmd_b/cmd_opcode into calc_input1/2/opcode; latch the tag; load the counter with SETTLE_CYCLES-1; go to DRIVE.
- IDLE, cmd_valid=1, error command (opcode 4 or 5 with cmd_b==0, or opcode 12-15):
  - Do not update calc_*.
  - rsp_result = 8'hFF for div/mod-by-zero, 0 for unused opcode.
  - rsp_overflow=0, rsp_err=1; latch the tag; go to RESP.
- DRIVE:
  - Counter != 0: decrement.
  - Counter == 0: capture rsp_result=calc_result and rsp_overflow=calc_overflow, set rsp_err=0, go to RESP.
- Latency: if the command handshake occurs at edge k, rsp_valid rises at edge k+SETTLE_CYCLES (legal) or edge k+1 (error).
- RESP:
  - On an edge with rsp_ready=1: go to IDLE.
  - On that same edge, ovf_count increments if rsp_overflow=1 and err_count increments if rsp_err=1. Each counter holds at all-ones.
  - rsp_ready=0: hold indefinitely.
- cmd_ready is low outside IDLE. A command cannot be accepted in the same cycle as a response handshake, so minimum issue spacing is SETTLE_CYCLES+2 cycles for a legal command.
- calc_* hold their last values after capture; they change only on acceptance of a legal command.
- Arithmetic is performed solely by the external calculator. The driver does no width extension; the calculator's 9-bit {overflow, result} is taken as-is (subtract underflow appears as overflow=1).
- cmd_* ignored when cmd_ready=0; rsp_ready ignored when rsp_valid=0.

Decomposition:
- Shared package calc_pkg:
  - opcode localparams (OP_ADD..OP_GT, OP_LAST_LEGAL=11)
  - state enum {IDLE, DRIVE, RESP}
  - DIVZERO_RESULT=8'hFF
- One natural sub-module: sat_counter (CNT_W, inc, clear via rst), instantiated twice for ovf_count and err_count.
- The bench instantiates the real calculator on the calc_* ports.

Test Plan:
- SETTLE_CYCLES=1: cmd (op 0, a=10, b=5, tag 3) handshake at edge k -> rsp_valid at edge k+1; result 15, overflow 0, err 0, tag 3.
- op 0 a=200 b=100 -> result 44, overflow 1, ovf_count 1; op 3 a=20 b=20 -> result 144, overflow 1, ovf_count 2; op 2 a=5 b=10 -> result 251, overflow 1, ovf_count 3.
- op 4 a=10 b=0 -> rsp_valid at k+1; result 8'hFF, err 1; calc_* unchanged from the prior command; err_count 1. op 13 -> result 0, err 1, err_count 2.
- Backpressure: after op 11 a=10 b=5, hold rsp_ready=0 for 5 cycles -> rsp_* stable, result 1, cmd_ready=0 throughout; rsp_ready=1 -> IDLE the next cycle. SETTLE_CYCLES=3 -> rsp_valid at k+3.
- Reset asserted mid-DRIVE and again in RESP with rsp_ready=0 -> after the edge, all outputs 0 and state IDLE; the next command completes normally.
- Saturation: 260 overflowing commands -> ovf_count holds at 255.
